// File: rtl/mandelbrot_frame_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mandelbrot_frame_sched_pkg                                      |
// | Purpose  : Shared definitions for the mandelbrot frame scheduler: default  |
// |            geometry, FSM state encodings and the output pixel word.        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mandelbrot_frame_sched_pkg;

  localparam int DEF_BITWIDTH   = 10;
  localparam int DEF_CTRWIDTH   = 7;
  localparam int DEF_WIDTH      = 320;
  localparam int DEF_HEIGHT     = 240;
  localparam int DEF_FIFO_DEPTH = 4;

  // Scheduler states. Kept as plain constants so older code that decodes the
  // state bits directly still lines up.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  // One buffered pixel: engine counter plus position tags.
  typedef struct packed {
    logic [3:0] ctr;
    logic       sol;   // first pixel of a line
    logic       eol;   // last pixel of a line
    logic       eof;   // last pixel of the frame
  } pix_word_t;

  function automatic pix_word_t make_pix(input logic [3:0] ctr,
                                         input logic       first_x,
                                         input logic       last_x,
                                         input logic       last_pix);
    pix_word_t w;
    w.ctr = ctr;
    w.sol = first_x;
    w.eol = last_x;
    w.eof = last_pix;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mandelbrot_pix_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mandelbrot_pix_fifo                                             |
// | Purpose  : Small synchronous FIFO for scheduled pixels, with occupancy     |
// |            count and a single-cycle flush.                                 |
// | Ports    : clk, reset (sync, active-high), flush                           |
// |            push / push_data     write side                                 |
// |            pop  / pop_data      read side (pop_data valid while !empty)    |
// |            empty, count         status                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mandelbrot_pix_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign push_ok  = push & (count_q != FULL_CNT);
  assign pop_ok   = pop & (count_q != '0);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mandelbrot_frame_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mandelbrot_frame_sched                                          |
// | Purpose  : Frame scheduler for the mandelbrot engine. Issues one engine    |
// |            run per pixel, collects the iteration count and streams tagged  |
// |            pixels out. View config is shadowed per frame so pan/zoom never |
// |            tears a frame; the engine is throttled on output back-pressure. |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            start, continuous, abort         frame control                  |
// |            cfg_*                            live view config               |
// |            eng_run/reset/running/finished/ctr_out  engine handshake        |
// |            eng_* config                     per-frame shadow config        |
// |            pix_valid/ready/data/sol/eol/eof output pixel stream            |
// |            busy, frame_done, frame_cnt, sync_err   status                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mandelbrot_frame_sched
  import mandelbrot_frame_sched_pkg::*;
#(
  parameter int BITWIDTH   = DEF_BITWIDTH,
  parameter int CTRWIDTH   = DEF_CTRWIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] cfg_cr_offset,
  input  logic [BITWIDTH-1:0] cfg_ci_offset,
  input  logic [1:0]          cfg_scaling,
  input  logic [CTRWIDTH-1:0] cfg_max_ctr,
  input  logic [1:0]          cfg_ctr_select,
  output logic                eng_run,
  output logic                eng_reset,
  input  logic                eng_running,
  input  logic                eng_finished,
  input  logic [3:0]          eng_ctr_out,
  output logic [BITWIDTH-1:0] eng_cr_offset,
  output logic [BITWIDTH-1:0] eng_ci_offset,
  output logic [1:0]          eng_scaling,
  output logic [CTRWIDTH-1:0] eng_max_ctr,
  output logic [1:0]          eng_ctr_select,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [3:0]          pix_data,
  output logic                pix_sol,
  output logic                pix_eol,
  output logic                pix_eof,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_cnt,
  output logic                sync_err
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  logic [2:0]          state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [BITWIDTH-1:0] cr_q, cr_d, ci_q, ci_d;
  logic [1:0]          scaling_q, scaling_d;
  logic [CTRWIDTH-1:0] max_ctr_q, max_ctr_d;
  logic [1:0]          ctr_sel_q, ctr_sel_d;
  logic                running_q, running_d;
  logic                abort_pend_q, abort_pend_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                sync_err_q, sync_err_d;

  logic                done;
  logic                last_pix;
  logic                fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CW-1:0]       fifo_count;
  pix_word_t           push_word, pop_word;

  // Falling edge of eng_running. running_q is always 0 in the first WAIT
  // cycle (ISSUE only fires while the engine is idle), so a late-rising
  // eng_running cannot be mistaken for a completion.
  assign running_d = eng_running;
  assign done      = running_q & ~eng_running;
  assign last_pix  = (x_q == X_LAST) & (y_q == Y_LAST);
  assign push_word = make_pix(eng_ctr_out, x_q == '0, x_q == X_LAST, last_pix);

  assign fifo_flush = (state_q == S_ABORT);
  assign fifo_pop   = pix_valid & pix_ready;

  mandelbrot_pix_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(pix_word_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (pop_word),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = pop_word.ctr;
  assign pix_sol   = pop_word.sol;
  assign pix_eol   = pop_word.eol;
  assign pix_eof   = pop_word.eof;

  assign eng_reset      = reset | (state_q == S_ABORT);
  assign eng_cr_offset  = cr_q;
  assign eng_ci_offset  = ci_q;
  assign eng_scaling    = scaling_q;
  assign eng_max_ctr    = max_ctr_q;
  assign eng_ctr_select = ctr_sel_q;

  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign sync_err  = sync_err_q;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    scaling_d    = scaling_q;
    max_ctr_d    = max_ctr_q;
    ctr_sel_d    = ctr_sel_q;
    abort_pend_d = abort_pend_q;
    frame_cnt_d  = frame_cnt_q;
    sync_err_d   = sync_err_q;
    eng_run      = 1'b0;
    fifo_push    = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start & ~abort) state_d = S_LOAD;
      end
      S_LOAD: begin
        cr_d      = cfg_cr_offset;
        ci_d      = cfg_ci_offset;
        scaling_d = cfg_scaling;
        max_ctr_d = cfg_max_ctr;
        ctr_sel_d = cfg_ctr_select;
        x_d       = '0;
        y_d       = '0;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if ((fifo_count < FIFO_FULL) & ~eng_running) begin
          // Only issue with a free FIFO slot, so the push on completion
          // can never meet a full FIFO.
          eng_run = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (done) begin
          if (abort | abort_pend_q) begin
            state_d = S_ABORT;
          end else begin
            fifo_push = 1'b1;
            // Engine's own end-of-frame flag must agree with our counters.
            if (last_pix != eng_finished) sync_err_d = 1'b1;
            if (x_q == X_LAST) begin
              x_d = '0;
              if (!last_pix) y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            state_d = last_pix ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          frame_done  = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = (continuous & ~abort) ? S_LOAD : S_IDLE;
        end
      end
      S_ABORT: begin
        x_d          = '0;
        y_d          = '0;
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      scaling_q    <= '0;
      max_ctr_q    <= '0;
      ctr_sel_q    <= '0;
      running_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      frame_cnt_q  <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      scaling_q    <= scaling_d;
      max_ctr_q    <= max_ctr_d;
      ctr_sel_q    <= ctr_sel_d;
      running_q    <= running_d;
      abort_pend_q <= abort_pend_d;
      frame_cnt_q  <= frame_cnt_d;
      sync_err_q   <= sync_err_d;
    end
  end

endmodule
`default_nettype wire
